// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: pcsource encodings, fetch FSM
// states and the default reset vector.
package mips_pkg;

   localparam logic [1:0] PCS_SEQ = 2'b00;
   localparam logic [1:0] PCS_BR  = 2'b01;
   localparam logic [1:0] PCS_JR  = 2'b10;
   localparam logic [1:0] PCS_J   = 2'b11;

   localparam logic [31:0] RESET_VEC = 32'h0000_0000;

   typedef enum logic [0:0] {
      ST_FETCH = 1'b0,
      ST_HOLD  = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake toward imem plus the
// instruction/redirect handshake toward decode and the core.
interface fetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_ack;
   logic [1:0]  pcsource;
   logic [15:0] br_offset;
   logic [31:0] jr_target;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        addr_err;

   modport master (
      output imem_req, imem_addr, inst, inst_valid, pc, pc_plus4, addr_err,
      input  imem_ready, imem_rdata, inst_ack, pcsource, br_offset, jr_target
   );

   modport slave (
      input  imem_req, imem_addr, inst, inst_valid, pc, pc_plus4, addr_err,
      output imem_ready, imem_rdata, inst_ack, pcsource, br_offset, jr_target
   );

endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection; shared with the pipelined fetch variants.
module next_pc_calc
   import mips_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [1:0]  pcsource,
   input  logic [15:0] br_offset,
   input  logic [31:0] jr_target,
   input  logic [25:0] inst_idx,
   output logic [31:0] pc_plus4,
   output logic [31:0] next_pc
);

   logic [31:0] br_disp;

   assign pc_plus4 = pc + 32'd4;
   assign br_disp  = {{14{br_offset[15]}}, br_offset, 2'b00};

   always_comb begin
      next_pc = pc_plus4;
      unique case (pcsource)
         PCS_SEQ: next_pc = pc_plus4;
         PCS_BR:  next_pc = pc_plus4 + br_disp;
         // low bits are forced aligned; misalignment is flagged by the caller
         PCS_JR:  next_pc = {jr_target[31:2], 2'b00};
         PCS_J:   next_pc = {pc_plus4[31:28], inst_idx, 2'b00};
         default: next_pc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Two-state fetch stage: FETCH waits for imem_ready, HOLD presents the
// instruction until the core acks it and supplies the redirect.
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_VEC
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
);

   fetch_state_t state, state_nxt;
   logic [31:0]  pc_q;
   logic [31:0]  inst_q;
   logic         addr_err_q;
   logic [31:0]  next_pc;
   logic [31:0]  pc_plus4;
   logic         cap_inst;
   logic         retire;
   logic         jr_misalign;

   next_pc_calc u_next_pc (
      .pc        (pc_q),
      .pcsource  (bus.pcsource),
      .br_offset (bus.br_offset),
      .jr_target (bus.jr_target),
      .inst_idx  (inst_q[25:0]),
      .pc_plus4  (pc_plus4),
      .next_pc   (next_pc)
   );

   assign cap_inst    = (state == ST_FETCH) && bus.imem_ready;
   assign retire      = (state == ST_HOLD) && bus.inst_ack;
   assign jr_misalign = (bus.pcsource == PCS_JR) && (bus.jr_target[1:0] != 2'b00);

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_FETCH: if (bus.imem_ready) state_nxt = ST_HOLD;
         ST_HOLD:  if (bus.inst_ack)   state_nxt = ST_FETCH;
         default:  state_nxt = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_FETCH;
         pc_q       <= RESET_PC;
         inst_q     <= 32'h0;
         addr_err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (cap_inst) inst_q <= bus.imem_rdata;
         if (retire) begin
            pc_q <= next_pc;
            if (jr_misalign) addr_err_q <= 1'b1;
         end
      end
   end

   // request is gated by rst so nothing is issued while reset is held
   assign bus.imem_req   = (state == ST_FETCH) && !rst;
   assign bus.imem_addr  = pc_q;
   assign bus.inst       = inst_q;
   assign bus.inst_valid = (state == ST_HOLD);
   assign bus.pc         = pc_q;
   assign bus.pc_plus4   = pc_plus4;
   assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized checks of fetch_unit against an arithmetic model
// of the PC/instruction/error state.
module tb_fetch_unit;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   logic [31:0] m_pc;
   logic [31:0] m_inst;
   logic        m_err;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] inst,
                                              input logic [1:0] ps, input logic [15:0] off,
                                              input logic [31:0] jt);
      logic [31:0] r;
      case (ps)
         2'd0:    r = pc + 32'd4;
         2'd1:    r = pc + 32'd4 + 32'($signed(off) * 4);
         2'd2:    r = jt & ~32'h3;
         default: r = ((pc + 32'd4) & 32'hF000_0000) | ((inst & 32'h03FF_FFFF) << 2);
      endcase
      return r;
   endfunction

   // called #1 after an edge with the DUT in FETCH; leaves it in HOLD
   task automatic do_fetch(input logic [31:0] word, input int waits);
      for (int w = 0; w < waits; w++) begin
         bus.imem_ready = 1'b0;
         bus.imem_rdata = $urandom;
         chk("wait_req",   32'(bus.imem_req),   32'd1);
         chk("wait_addr",  bus.imem_addr,       m_pc);
         chk("wait_valid", 32'(bus.inst_valid), 32'd0);
         @(posedge clk); #1;
      end
      bus.imem_ready = 1'b1;
      bus.imem_rdata = word;
      chk("fetch_req",  32'(bus.imem_req), 32'd1);
      chk("fetch_addr", bus.imem_addr,     m_pc);
      @(posedge clk); #1;
      bus.imem_ready = 1'b0;
      bus.imem_rdata = $urandom;
      m_inst = word;
      chk("hold_valid", 32'(bus.inst_valid), 32'd1);
      chk("hold_inst",  bus.inst,            m_inst);
      chk("hold_req",   32'(bus.imem_req),   32'd0);
      chk("hold_pc4",   bus.pc_plus4,        m_pc + 32'd4);
   endtask

   // called in HOLD; stalls, then retires with the given redirect
   task automatic do_ack(input logic [1:0] ps, input logic [15:0] off,
                         input logic [31:0] jt, input int stalls);
      logic [31:0] exp;
      for (int s = 0; s < stalls; s++) begin
         bus.inst_ack   = 1'b0;
         bus.pcsource   = 2'($urandom);
         bus.jr_target  = $urandom;
         bus.br_offset  = 16'($urandom);
         bus.imem_ready = 1'($urandom);
         bus.imem_rdata = $urandom;
         @(posedge clk); #1;
         chk("stall_inst",  bus.inst,            m_inst);
         chk("stall_valid", 32'(bus.inst_valid), 32'd1);
         chk("stall_pc",    bus.pc,              m_pc);
         chk("stall_req",   32'(bus.imem_req),   32'd0);
         chk("stall_err",   32'(bus.addr_err),   32'(m_err));
      end
      bus.imem_ready = 1'b0;
      bus.inst_ack   = 1'b1;
      bus.pcsource   = ps;
      bus.br_offset  = off;
      bus.jr_target  = jt;
      exp = model_next(m_pc, m_inst, ps, off, jt);
      if (ps == 2'd2 && jt[1:0] != 2'b00) m_err = 1'b1;
      @(posedge clk); #1;
      bus.inst_ack = 1'b0;
      m_pc = exp;
      chk("ack_pc",    bus.pc,              m_pc);
      chk("ack_addr",  bus.imem_addr,       m_pc);
      chk("ack_req",   32'(bus.imem_req),   32'd1);
      chk("ack_valid", 32'(bus.inst_valid), 32'd0);
      chk("ack_err",   32'(bus.addr_err),   32'(m_err));
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_pc"},    bus.pc,              32'h0);
      chk({tag, "_inst"},  bus.inst,            32'h0);
      chk({tag, "_valid"}, 32'(bus.inst_valid), 32'd0);
      chk({tag, "_req"},   32'(bus.imem_req),   32'd0);
      chk({tag, "_err"},   32'(bus.addr_err),   32'd0);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      bus.imem_ready = 1'b0;
      bus.imem_rdata = 32'h0;
      bus.inst_ack   = 1'b0;
      bus.pcsource   = 2'd0;
      bus.br_offset  = 16'h0;
      bus.jr_target  = 32'h0;
      m_pc = 32'h0; m_inst = 32'h0; m_err = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("rst");
      rst = 1'b0;
      #1;
      chk("rel_req",  32'(bus.imem_req), 32'd1);
      chk("rel_addr", bus.imem_addr,     32'h0);

      do_fetch(32'h2008_0005, 0);
      do_ack(2'd0, 16'h0, 32'h0, 0);               // -> 4
      do_fetch(32'h0000_0020, 0);
      do_ack(2'd0, 16'h0, 32'h0, 0);               // -> 8
      do_fetch(32'h1234_5678, 3);                  // wait states at 8
      do_ack(2'd0, 16'h0, 32'h0, 0);               // -> C
      do_fetch($urandom, 0);
      do_ack(2'd0, 16'h0, 32'h0, 0);               // -> 10
      do_fetch($urandom, 0);
      do_ack(2'd1, 16'hFFFE, 32'h0, 0);            // -> C
      chk("br_back", bus.pc, 32'h0000_000C);
      do_fetch($urandom, 0);
      do_ack(2'd0, 16'h0, 32'h0, 0);               // -> 10
      do_fetch($urandom, 0);
      do_ack(2'd1, 16'h0003, 32'h0, 0);            // -> 20
      chk("br_fwd", bus.pc, 32'h0000_0020);
      do_fetch($urandom, 0);
      do_ack(2'd2, 16'h0, 32'h4000_0000, 0);
      do_fetch(32'h0C00_0100, 0);
      chk("jal_pc4", bus.pc_plus4, 32'h4000_0004);
      do_ack(2'd3, 16'h0, 32'h0, 0);
      chk("jal_pc", bus.pc, 32'h4000_0400);
      do_fetch($urandom, 1);
      do_ack(2'd2, 16'h0, 32'h0000_0102, 0);
      chk("jr_pc",  bus.pc,             32'h0000_0100);
      chk("jr_err", 32'(bus.addr_err),  32'd1);
      do_fetch($urandom, 0);
      do_ack(2'd0, 16'h0, 32'h0, 5);               // stall, then 104
      do_fetch($urandom, 0);
      do_ack(2'd2, 16'h0, 32'hFFFF_FFFC, 0);
      do_fetch($urandom, 0);
      do_ack(2'd0, 16'h0, 32'h0, 0);
      chk("wrap_pc", bus.pc, 32'h0);
      chk("err_sticky", 32'(bus.addr_err), 32'd1);

      for (int i = 0; i < 40; i++) begin
         do_fetch($urandom, int'($urandom_range(0, 2)));
         do_ack(2'($urandom), 16'($urandom), $urandom, int'($urandom_range(0, 2)));
      end

      // asynchronous reset mid-HOLD at pc=40
      do_fetch($urandom, 0);
      do_ack(2'd2, 16'h0, 32'h0000_0040, 0);
      do_fetch(32'hDEAD_BEEF, 0);
      #2 rst = 1'b1;
      #1;
      chk_reset_state("async");
      @(posedge clk); #1;
      rst = 1'b0;
      m_pc = 32'h0; m_inst = 32'h0; m_err = 1'b0;
      #1;
      chk("post_rst_addr", bus.imem_addr,     32'h0);
      chk("post_rst_req",  32'(bus.imem_req), 32'd1);
      do_fetch(32'h2008_0005, 1);
      do_ack(2'd0, 16'h0, 32'h0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Sequential instruction-fetch stage for the single-cycle MIPS core; owns the program counter.
- Upstream of the control decoder: supplies the instruction word whose op/func fields it decodes.
- Downstream of the decoder: consumes its 2-bit pcsource and computes the next PC.
- Adds a ready/ack handshake so instruction memory may take more than one cycle.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; equals pc
- imem_ready  in  1  imem_rdata valid this cycle
- imem_rdata  in  32  instruction word from memory
- inst  out  32  registered instruction presented to decode/datapath
- inst_valid  out  1  inst is valid and awaiting retirement
- inst_ack  in  1  core retires inst this cycle; pcsource and targets are valid
- pcsource  in  2  00 = pc+4, 01 = branch, 10 = jr, 11 = j/jal
- br_offset  in  16  instruction imm field, branch word offset
- jr_target  in  32  rs register value for jr
- pc  out  32  address of the current instruction
- pc_plus4  out  32  pc+4, used as the jal link value
- addr_err  out  1  sticky: a misaligned jr target was taken

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - state=FETCH, pc=RESET_PC, inst=0, inst_valid=0, addr_err=0.
  - imem_req=0 while rst is asserted.
- FSM has two states, FETCH and HOLD.
- FETCH:
  - imem_req=1, imem_addr=pc, inst_valid=0.
  - If imem_ready=1 at a clock edge: inst<=imem_rdata and state<=HOLD.
  - Otherwise remain in FETCH with the address held stable.
  - imem_ready is ignored outside FETCH.
- HOLD:
  - imem_req=0, inst_valid=1, inst stable.
  - On an edge with inst_ack=1: pc<=next_pc, state<=FETCH.
  - Without inst_ack, remain in HOLD indefinitely; no timeout.
- Next-PC rule, evaluated combinationally from pc and sampled only on ack:
  - 00 -> pc+4
  - 01 -> pc+4 + (sign_extend(br_offset) << 2)
  - 10 -> {jr_target[31:2], 2'b00}
  - 11 -> {pc_plus4[31:28], inst[25:0], 2'b00}
- All arithmetic is 32-bit modulo 2^32; wrap-around (e.g. pc=32'hFFFF_FFFC, pcsource=00 -> 0) is silent.
- addr_err is set when inst_ack=1, pcsource=10 and jr_target[1:0]!=0. It is cleared only by reset. The PC still advances to the aligned target.
- Latency:
  - Minimum 2 cycles per instruction: FETCH with ready, then HOLD with ack.
  - inst_valid rises the cycle after imem_ready.
- pc_plus4 = pc+4, combinational. pc changes only on ack edges or reset.
- Reset mid-operation, in either state: the outstanding fetch or instruction is discarded. The next fetch after reset release goes to RESET_PC.

Decomposition:
- Shared package (mips_pkg):
  - pcsource encodings: PCS_SEQ=2'b00, PCS_BR=2'b01, PCS_JR=2'b10, PCS_J=2'b11.
  - FSM state constants: ST_FETCH, ST_HOLD.
  - Reset vector default.
- One natural sub-module, next_pc_calc: purely combinational, computes the 32-bit next PC from pc, pcsource, br_offset, jr_target and inst[25:0]. It is shared with later pipelined variants.
- The FSM and registers stay in fetch_unit.

Test Plan:
- Reset and sequential fetch:
  - Release rst with imem_ready=1 and imem_rdata=32'h2008_0005 (addi).
  - Expect imem_addr=0; one cycle later inst_valid=1 and inst=32'h2008_0005.
  - Ack with pcsource=00 -> next imem_addr=4.
- Memory wait states:
  - Hold imem_ready=0 for 3 cycles at pc=8.
  - Expect imem_req=1 and imem_addr=8 stable, inst_valid=0 throughout.
  - inst is captured on the 4th-cycle ready.
- Branches:
  - At pc=32'h0000_0010, ack with pcsource=01 and br_offset=16'hFFFE -> pc=32'h0000_000C.
  - With br_offset=16'h0003 -> pc=32'h0000_0020.
- Jump and jr:
  - At pc=32'h4000_0000 with inst=32'h0C00_0100 (jal), ack with pcsource=11 -> pc=32'h4000_0400; pc_plus4 was 32'h4000_0004 during HOLD.
  - jr with jr_target=32'h0000_0102 -> pc=32'h0000_0100 and addr_err=1, which stays set.
- Stall on ack:
  - Hold inst_ack=0 for 5 cycles in HOLD.
  - Expect inst, pc and inst_valid stable, and imem_req=0.
  - Changes to pcsource/jr_target during the stall have no effect until ack.
- Asynchronous reset mid-HOLD:
  - Assert rst between edges at pc=32'h0000_0040.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, the first imem_addr=RESET_PC.
  - Also cover the wrap case: pc=32'hFFFF_FFFC acked with pcsource=00 -> pc=0.
